// File: rtl/cam_pattern_gen.sv
// OV7670-style camera timing generator emitting synthetic RGB565 byte streams.
// Frame = vsync pulse, back porch, then V_LINES of (H_BYTES active + H_BLANK idle).
module cam_pattern_gen #(
    parameter int DATA_W    = 8,
    parameter int H_BYTES   = 640,
    parameter int H_BLANK   = 119,
    parameter int V_LINES   = 240,
    parameter int VSYNC_CYC = 4704,
    parameter int VBP_CYC   = 26656
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [7:0]        num_frames,
    input  logic [15:0]       seed,
    output logic              vsync,
    output logic              href,
    output logic [DATA_W-1:0] data,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        frame_count
);

    localparam int VS_W   = (VSYNC_CYC > 1) ? $clog2(VSYNC_CYC) : 1;
    localparam int VBP_W  = (VBP_CYC > 1)   ? $clog2(VBP_CYC)   : 1;
    localparam int BYTE_W = (H_BYTES > 1)   ? $clog2(H_BYTES)   : 1;
    localparam int HB_W   = (H_BLANK > 1)   ? $clog2(H_BLANK)   : 1;
    localparam int LINE_W = (V_LINES > 1)   ? $clog2(V_LINES)   : 1;

    localparam logic [VS_W-1:0]   VS_LAST   = VS_W'(VSYNC_CYC - 1);
    localparam logic [VBP_W-1:0]  VBP_LAST  = VBP_W'(VBP_CYC - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(H_BYTES - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(H_BLANK - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
    localparam logic [DATA_W-1:0] PAT_CONST = DATA_W'(8'hAA);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_HBLANK
    } state_t;

    state_t              state_reg;
    logic [1:0]          mode_reg;
    logic [15:0]         lfsr_reg;
    logic [VS_W-1:0]     vs_cnt_reg;
    logic [VBP_W-1:0]    vbp_cnt_reg;
    logic [BYTE_W-1:0]   byte_cnt_reg;
    logic [HB_W-1:0]     hb_cnt_reg;
    logic [LINE_W-1:0]   line_cnt_reg;
    logic                vsync_reg;
    logic                href_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                frame_done_reg;
    logic                busy_reg;
    logic [7:0]          frame_count_reg;

    logic [15:0]         lfsr_next;
    logic [15:0]         seed_load;
    logic                last_line;
    logic                hb_almost_last;
    logic                continue_run;
    logic [DATA_W-1:0]   first_byte_data;
    logic [DATA_W-1:0]   next_byte_data;
    logic [DATA_W-1:0]   next_line_data;

    // Fibonacci LFSR, taps 16,14,13,11: shift up, feedback into bit 0
    assign lfsr_next[0] = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    assign seed_load      = (seed == 16'd0) ? 16'h0001 : seed;
    assign last_line      = (line_cnt_reg == LINE_LAST);
    assign hb_almost_last = ((int'(hb_cnt_reg) + 2) == H_BLANK);
    assign continue_run   = enable &&
                            ((num_frames == 8'd0) ||
                             (({1'b0, frame_count_reg} + 9'd1) < {1'b0, num_frames}));

    function automatic logic [DATA_W-1:0] pattern_byte(
        input logic [1:0]        sel,
        input logic [BYTE_W-1:0] byte_idx,
        input logic [LINE_W-1:0] line_idx,
        input logic [15:0]       lfsr
    );
        logic [DATA_W-1:0] b;
        case (sel)
            2'd0:    b = PAT_CONST;
            2'd1:    b = DATA_W'(byte_idx);
            2'd2:    b = DATA_W'(lfsr);
            default: b = DATA_W'(line_idx);
        endcase
        return b;
    endfunction

    // Data is registered on the edge entering each href cycle, so the byte
    // for that cycle is computed from the position it is about to occupy.
    assign first_byte_data = pattern_byte(mode_reg, '0, line_cnt_reg, lfsr_reg);
    assign next_byte_data  = pattern_byte(mode_reg, byte_cnt_reg + BYTE_W'(1), line_cnt_reg, lfsr_reg);
    assign next_line_data  = pattern_byte(mode_reg, '0, line_cnt_reg + LINE_W'(1), lfsr_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            mode_reg        <= 2'd0;
            lfsr_reg        <= 16'h0001;
            vs_cnt_reg      <= '0;
            vbp_cnt_reg     <= '0;
            byte_cnt_reg    <= '0;
            hb_cnt_reg      <= '0;
            line_cnt_reg    <= '0;
            vsync_reg       <= 1'b0;
            href_reg        <= 1'b0;
            data_reg        <= '0;
            frame_done_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            frame_count_reg <= 8'd0;
        end else begin
            frame_done_reg <= 1'b0;
            unique case (state_reg)
                S_IDLE: begin
                    if (enable) begin
                        state_reg       <= S_VSYNC;
                        vsync_reg       <= 1'b1;
                        busy_reg        <= 1'b1;
                        mode_reg        <= mode;
                        lfsr_reg        <= seed_load;
                        frame_count_reg <= 8'd0;
                        vs_cnt_reg      <= '0;
                        line_cnt_reg    <= '0;
                    end
                end
                S_VSYNC: begin
                    if (vs_cnt_reg == VS_LAST) begin
                        state_reg   <= S_VBP;
                        vsync_reg   <= 1'b0;
                        vs_cnt_reg  <= '0;
                        vbp_cnt_reg <= '0;
                    end else begin
                        vs_cnt_reg <= vs_cnt_reg + VS_W'(1);
                    end
                end
                S_VBP: begin
                    if (vbp_cnt_reg == VBP_LAST) begin
                        state_reg    <= S_ACTIVE;
                        vbp_cnt_reg  <= '0;
                        byte_cnt_reg <= '0;
                        href_reg     <= 1'b1;
                        data_reg     <= first_byte_data;
                        lfsr_reg     <= lfsr_next;
                    end else begin
                        vbp_cnt_reg <= vbp_cnt_reg + VBP_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (byte_cnt_reg == BYTE_LAST) begin
                        state_reg      <= S_HBLANK;
                        byte_cnt_reg   <= '0;
                        hb_cnt_reg     <= '0;
                        href_reg       <= 1'b0;
                        data_reg       <= '0;
                        frame_done_reg <= last_line && (H_BLANK == 1);
                    end else begin
                        byte_cnt_reg <= byte_cnt_reg + BYTE_W'(1);
                        data_reg     <= next_byte_data;
                        lfsr_reg     <= lfsr_next;
                    end
                end
                S_HBLANK: begin
                    if (hb_cnt_reg == HB_LAST) begin
                        hb_cnt_reg <= '0;
                        if (last_line) begin
                            // frame_done was raised for this cycle; now close the frame
                            frame_count_reg <= frame_count_reg + 8'd1;
                            line_cnt_reg    <= '0;
                            if (continue_run) begin
                                state_reg  <= S_VSYNC;
                                vsync_reg  <= 1'b1;
                                vs_cnt_reg <= '0;
                                mode_reg   <= mode;
                            end else begin
                                state_reg <= S_IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            state_reg    <= S_ACTIVE;
                            line_cnt_reg <= line_cnt_reg + LINE_W'(1);
                            href_reg     <= 1'b1;
                            data_reg     <= next_line_data;
                            lfsr_reg     <= lfsr_next;
                        end
                    end else begin
                        hb_cnt_reg     <= hb_cnt_reg + HB_W'(1);
                        frame_done_reg <= last_line && hb_almost_last;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign vsync       = vsync_reg;
    assign href        = href_reg;
    assign data        = data_reg;
    assign frame_done  = frame_done_reg;
    assign busy        = busy_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Randomized bench for cam_pattern_gen against a frame-position reference model.
module tb_cam_pattern_gen;

    localparam int DATA_W    = 8;
    localparam int H_BYTES   = 8;
    localparam int H_BLANK   = 3;
    localparam int V_LINES   = 4;
    localparam int VSYNC_CYC = 5;
    localparam int VBP_CYC   = 6;
    localparam int LINE_LEN  = H_BYTES + H_BLANK;
    localparam int ACT_START = VSYNC_CYC + VBP_CYC;
    localparam int FRAME_LEN = ACT_START + V_LINES * LINE_LEN;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [7:0]        num_frames = 8'd0;
    logic [15:0]       seed = 16'd0;
    logic              vsync;
    logic              href;
    logic [DATA_W-1:0] data;
    logic              frame_done;
    logic              busy;
    logic [7:0]        frame_count;

    cam_pattern_gen #(
        .DATA_W    (DATA_W),
        .H_BYTES   (H_BYTES),
        .H_BLANK   (H_BLANK),
        .V_LINES   (V_LINES),
        .VSYNC_CYC (VSYNC_CYC),
        .VBP_CYC   (VBP_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .num_frames  (num_frames),
        .seed        (seed),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .frame_done  (frame_done),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference model: run flag, position within the frame, frames completed.
    bit          m_run = 1'b0;
    int          m_k = 0;
    int          m_frames = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [15:0] m_lfsr = 16'h0001;
    logic [19:0] exp_vec = '0;

    task automatic model_edge();
        int         pos;
        logic       hr;
        logic [7:0] d;
        if (rst) begin
            m_run = 1'b0; m_frames = 0; m_lfsr = 16'h0001;
        end else if (!m_run) begin
            if (enable) begin
                m_run = 1'b1; m_k = 0; m_frames = 0; m_mode = mode;
                m_lfsr = (seed == 16'd0) ? 16'h0001 : seed;
            end
        end else if (m_k == FRAME_LEN - 1) begin
            m_frames++;
            if (enable && (num_frames == 8'd0 || m_frames < int'(num_frames))) begin
                m_k = 0; m_mode = mode;
            end else begin
                m_run = 1'b0;
            end
            m_frames = m_frames % 256;
        end else begin
            m_k++;
        end
        hr = 1'b0;
        d  = 8'd0;
        if (m_run && m_k >= ACT_START) begin
            pos = (m_k - ACT_START) % LINE_LEN;
            if (pos < H_BYTES) begin
                hr = 1'b1;
                case (m_mode)
                    2'd0:    d = 8'hAA;
                    2'd1:    d = 8'(pos);
                    2'd2:    d = m_lfsr[7:0];
                    default: d = 8'((m_k - ACT_START) / LINE_LEN);
                endcase
                m_lfsr = lfsr_step(m_lfsr);
            end
        end
        exp_vec = {m_run && (m_k < VSYNC_CYC), hr, d,
                   m_run && (m_k == FRAME_LEN - 1), m_run, 8'(m_frames)};
    endtask

    int         cyc = 0;
    int         start = 0;
    int         vs_rises = 0;
    logic       vs_prev = 1'b0;
    int         fd_cycles[$];
    logic [7:0] href_bytes[$];

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_eq(tag, {12'd0, vsync, href, data, frame_done, busy, frame_count}, {12'd0, exp_vec});
        if (frame_done) begin
            fd_cycles.push_back(cyc);
            $display("frame end [%s] cycle=%0d frame_count=%0d", tag, cyc - start, frame_count);
        end
        if (vsync && !vs_prev) vs_rises++;
        vs_prev = vsync;
        if (href) href_bytes.push_back(data);
    endtask

    task automatic clear_logs();
        fd_cycles.delete();
        href_bytes.delete();
        vs_rises = 0;
        start = cyc;
    endtask

    task automatic check_fd(input string tag, input int n_exp);
        check_eq({tag, "_fd_count"}, fd_cycles.size(), n_exp);
        for (int i = 0; i < fd_cycles.size(); i++)
            check_eq({tag, "_fd_time"}, fd_cycles[i] - start, (i + 1) * FRAME_LEN);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drop;
        logic [15:0] ref_l;

        // Reset: outputs clear before any clock edge
        #1 rst = 1'b1;
        #2;
        check_eq("reset_async", {vsync, href, data, frame_done, busy, frame_count}, 0);
        repeat (2) tick("reset");
        rst = 1'b0;
        repeat (3) tick("idle");

        // Scenario 1: single counter-pattern frame
        clear_logs();
        mode = 2'd1; num_frames = 8'd1; seed = 16'($urandom); enable = 1'b1;
        tick("s1");
        enable = 1'b0;
        repeat (FRAME_LEN + 3) tick("s1");
        check_fd("s1", 1);
        check_eq("s1_bytes", href_bytes.size(), V_LINES * H_BYTES);
        for (int i = 0; i < href_bytes.size(); i++)
            check_eq("s1_byte", href_bytes[i], 32'(i % H_BYTES));
        check_eq("s1_count", frame_count, 1);
        check_eq("s1_busy", busy, 0);

        // Scenario 2: continuous, enable dropped in frame 4
        clear_logs();
        mode = 2'($urandom_range(0, 3)); num_frames = 8'd0; seed = 16'($urandom); enable = 1'b1;
        for (int i = 0; i < 6 * FRAME_LEN; i++) begin
            if (i == 3 * FRAME_LEN + 20) enable = 1'b0;
            tick("s2");
        end
        check_fd("s2", 4);
        check_eq("s2_count", frame_count, 4);
        check_eq("s2_busy", busy, 0);

        // Scenario 3: LFSR pattern with explicit and zero seed
        for (int s = 0; s < 2; s++) begin
            clear_logs();
            mode = 2'd2; num_frames = 8'd1;
            seed = (s == 0) ? 16'hACE1 : 16'h0000;
            enable = 1'b1;
            tick("s3");
            enable = 1'b0;
            repeat (FRAME_LEN + 3) tick("s3");
            check_eq("s3_bytes", href_bytes.size(), 32);
            check_eq("s3_first", href_bytes.size() > 0 ? href_bytes[0] : 8'h00,
                     (s == 0) ? 8'hE1 : 8'h01);
            ref_l = (s == 0) ? 16'hACE1 : 16'h0001;
            for (int i = 0; i < href_bytes.size(); i++) begin
                check_eq("s3_lfsr", href_bytes[i], ref_l[7:0]);
                ref_l = lfsr_step(ref_l);
            end
        end

        // Scenario 4: line-index pattern, mode change mid-frame takes effect next frame
        clear_logs();
        mode = 2'd3; num_frames = 8'd2; seed = 16'($urandom); enable = 1'b1;
        for (int i = 0; i < 2 * FRAME_LEN + 5; i++) begin
            if (i == 30) mode = 2'd0;
            if (i == FRAME_LEN + 10) enable = 1'b0;
            tick("s4");
        end
        check_fd("s4", 2);
        check_eq("s4_bytes", href_bytes.size(), 64);
        for (int i = 0; i < href_bytes.size(); i++)
            check_eq("s4_byte", href_bytes[i], (i < 32) ? 32'(i / H_BYTES) : 32'hAA);

        // Scenario 5: reset during line 2 active, then a clean frame
        clear_logs();
        mode = 2'($urandom_range(0, 3)); num_frames = 8'd0; seed = 16'($urandom); enable = 1'b1;
        for (int i = 0; i <= ACT_START + 2 * LINE_LEN + 3; i++) tick("s5_run");
        check_eq("s5_href_pre", href, 1);
        rst = 1'b1;
        #1;
        check_eq("s5_async", {vsync, href, data, frame_done, busy, frame_count}, 0);
        enable = 1'b0;
        repeat (2) tick("s5_rst");
        rst = 1'b0;
        repeat (3) tick("s5_idle");
        clear_logs();
        num_frames = 8'd1; enable = 1'b1;
        tick("s5_frame");
        enable = 1'b0;
        repeat (FRAME_LEN + 2) tick("s5_frame");
        check_fd("s5", 1);
        check_eq("s5_count", frame_count, 1);

        // Scenario 6: two-frame burst, no further vsync
        clear_logs();
        mode = 2'($urandom_range(0, 3)); num_frames = 8'd2; seed = 16'($urandom); enable = 1'b1;
        for (int i = 0; i < 3 * FRAME_LEN; i++) begin
            if (i == FRAME_LEN + 10) enable = 1'b0;
            tick("s6");
        end
        check_fd("s6", 2);
        check_eq("s6_count", frame_count, 2);
        check_eq("s6_vsync_rises", vs_rises, 2);
        check_eq("s6_busy", busy, 0);

        // Random runs: random mode/seed/frame count, mode jitter, random enable drop
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            mode = 2'($urandom_range(0, 3)); seed = 16'($urandom);
            num_frames = 8'($urandom_range(0, 3)); enable = 1'b1;
            drop = $urandom_range(FRAME_LEN + 5, 2 * FRAME_LEN);
            for (int i = 0; i < 3 * FRAME_LEN + 60; i++) begin
                if (i == drop) enable = 1'b0;
                if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
                tick("rand");
            end
            check_eq("rand_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
